// File: rtl/tcb_scheduler.sv
// -----------------------------------------------------------------------------
// tcb_scheduler
//
// Periodically schedules the trusted code base (TCB) held in secure memory on
// the openMSP430. A period counter raises a dedicated interrupt request. The
// core PC is then followed through request, entry, run and exit. Any departure
// from single-entry / single-exit, atomic, time-bounded TCB execution drives
// a reset to the core. That reset is OR-ed into the global monitor reset.
//
// Ports:
//   clk      in   1   core clock
//   rst_n    in   1   synchronous active-low reset
//   pc       in  16   current core program counter
//   irq      in   1   a non-TCB interrupt is being serviced
//   dma_en   in   1   DMA access active
//   tcb_irq  out  1   scheduling interrupt request to the core
//   reset    out  1   violation reset to the core
//   state    out  2   0 IDLE, 1 REQ, 2 RUN, 3 VIOLATION
//   pending  out  1   a period expiry is waiting to be served
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module tcb_scheduler #(
    parameter logic [15:0] TCB_BASE      = 16'hA000,
    parameter logic [15:0] TCB_SIZE      = 16'h4000,
    parameter logic [15:0] TCB_ENTRY     = 16'hA000,
    parameter logic [15:0] TCB_EXIT      = 16'hDFFE,
    parameter logic [15:0] PERIOD        = 16'd50000,
    parameter logic [15:0] MAX_WAIT      = 16'd1000,
    parameter logic [15:0] MAX_RUN       = 16'd20000,
    parameter logic [15:0] RESET_HANDLER = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] pc,
    input  logic        irq,
    input  logic        dma_en,
    output logic        tcb_irq,
    output logic        reset,
    output logic [1:0]  state,
    output logic        pending
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RUN  = 2'd2,
        ST_VIOL = 2'd3
    } state_t;

    // The region end is computed in 17 bits so that a region reaching the top
    // of the address space does not wrap to a small value.
    localparam logic [16:0] TCB_LAST    = {1'b0, TCB_BASE} + {1'b0, TCB_SIZE} - 17'd1;
    localparam logic [15:0] PERIOD_LAST = PERIOD - 16'd1;
    localparam logic [15:0] WAIT_LAST   = MAX_WAIT - 16'd1;
    localparam logic [15:0] RUN_LAST    = MAX_RUN - 16'd1;

    function automatic logic in_region(input logic [15:0] addr);
        logic [16:0] a;
        a = {1'b0, addr};
        return (a >= {1'b0, TCB_BASE}) && (a <= TCB_LAST);
    endfunction

    state_t      state_q,      state_d;
    logic [15:0] period_cnt_q, period_cnt_d;
    logic [15:0] wait_cnt_q,   wait_cnt_d;
    logic [15:0] run_cnt_q,    run_cnt_d;
    logic        pending_q,    pending_d;
    logic        tcb_irq_q,    tcb_irq_d;
    logic        reset_q,      reset_d;
    logic [15:0] pc_prev_q;

    logic in_tcb;
    logic prev_in_tcb;
    logic entry_edge;
    logic exit_edge;
    logic legal_entry;
    logic illegal_entry;
    logic period_exp;

    assign in_tcb        = in_region(pc);
    assign prev_in_tcb   = in_region(pc_prev_q);
    assign entry_edge    = !prev_in_tcb && in_tcb;
    assign exit_edge     = prev_in_tcb && !in_tcb;
    assign legal_entry   = entry_edge && (pc == TCB_ENTRY);
    assign illegal_entry = entry_edge && (pc != TCB_ENTRY);
    assign period_exp    = (period_cnt_q == PERIOD_LAST);

    always_comb begin
        state_d      = state_q;
        period_cnt_d = period_cnt_q;
        pending_d    = pending_q;
        wait_cnt_d   = '0;
        run_cnt_d    = '0;
        tcb_irq_d    = 1'b0;
        reset_d      = 1'b0;

        // Period counter and the pending flag. They have the lowest priority:
        // the state-specific logic below may override them. pending saturates
        // at 1, so a second expiry while one is still waiting is absorbed.
        if (state_q == ST_VIOL) begin
            period_cnt_d = '0;
        end else if (period_exp) begin
            period_cnt_d = '0;
            pending_d    = 1'b1;
        end else begin
            period_cnt_d = period_cnt_q + 16'd1;
        end

        unique case (state_q)
            ST_IDLE: begin
                // An expiry on this very edge also counts. This lets the
                // request go out together with pending.
                if (illegal_entry) begin
                    state_d = ST_VIOL;
                end else if (legal_entry) begin
                    state_d   = ST_RUN;
                    pending_d = 1'b0;
                end else if ((pending_q || period_exp) && !in_tcb) begin
                    state_d = ST_REQ;
                end
            end

            ST_REQ: begin
                wait_cnt_d = wait_cnt_q + 16'd1;
                if (illegal_entry) begin
                    state_d = ST_VIOL;
                end else if (legal_entry) begin
                    state_d   = ST_RUN;
                    pending_d = 1'b0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    // The request was ignored or masked for too long.
                    state_d = ST_VIOL;
                end
            end

            ST_RUN: begin
                run_cnt_d = run_cnt_q + 16'd1;
                if (irq || dma_en) begin
                    // The TCB must run atomically.
                    state_d = ST_VIOL;
                end else if (exit_edge) begin
                    // Only the designated exit instruction may leave the TCB.
                    state_d = (pc_prev_q == TCB_EXIT) ? ST_IDLE : ST_VIOL;
                end else if (illegal_entry) begin
                    state_d = ST_VIOL;
                end else if (run_cnt_q == RUN_LAST) begin
                    // The time budget is used up and the PC is still inside.
                    state_d = ST_VIOL;
                end
            end

            ST_VIOL: begin
                pending_d = 1'b0;
                if (pc == RESET_HANDLER) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // VIOLATION clears all bookkeeping on the same edge that enters it.
        if (state_d == ST_VIOL) begin
            period_cnt_d = '0;
            pending_d    = 1'b0;
        end
        if (state_d != ST_REQ) begin
            wait_cnt_d = '0;
        end
        if (state_d != ST_RUN) begin
            run_cnt_d = '0;
        end

        // The outputs are a registered decode of the next state.
        tcb_irq_d = (state_d == ST_REQ);
        reset_d   = (state_d == ST_VIOL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            period_cnt_q <= '0;
            wait_cnt_q   <= '0;
            run_cnt_q    <= '0;
            pending_q    <= 1'b0;
            tcb_irq_q    <= 1'b0;
            reset_q      <= 1'b0;
            pc_prev_q    <= RESET_HANDLER;
        end else begin
            state_q      <= state_d;
            period_cnt_q <= period_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            run_cnt_q    <= run_cnt_d;
            pending_q    <= pending_d;
            tcb_irq_q    <= tcb_irq_d;
            reset_q      <= reset_d;
            pc_prev_q    <= pc;
        end
    end

    assign tcb_irq = tcb_irq_q;
    assign reset   = reset_q;
    assign state   = state_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_tcb_scheduler.sv
// -----------------------------------------------------------------------------
// Bench for tcb_scheduler. There are two instances. Both use a short period
// and a short wait limit. They differ only in the run budget: 8 for "s" and
// 20 for "l". Each scenario queues per-cycle stimulus. Each queued step
// carries the expected {state, tcb_irq, reset, pending} after that edge.
// -----------------------------------------------------------------------------
module tb_tcb_scheduler;

    logic        clk;
    logic        rst_n;
    logic [15:0] pc;
    logic        irq;
    logic        dma_en;

    logic        tcb_irq_s, reset_s, pending_s;
    logic [1:0]  state_s;
    logic        tcb_irq_l, reset_l, pending_l;
    logic [1:0]  state_l;

    tcb_scheduler #(
        .PERIOD   (16'd10),
        .MAX_WAIT (16'd6),
        .MAX_RUN  (16'd8)
    ) dut_s (
        .clk     (clk),
        .rst_n   (rst_n),
        .pc      (pc),
        .irq     (irq),
        .dma_en  (dma_en),
        .tcb_irq (tcb_irq_s),
        .reset   (reset_s),
        .state   (state_s),
        .pending (pending_s)
    );

    tcb_scheduler #(
        .PERIOD   (16'd10),
        .MAX_WAIT (16'd6),
        .MAX_RUN  (16'd20)
    ) dut_l (
        .clk     (clk),
        .rst_n   (rst_n),
        .pc      (pc),
        .irq     (irq),
        .dma_en  (dma_en),
        .tcb_irq (tcb_irq_l),
        .reset   (reset_l),
        .state   (state_l),
        .pending (pending_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [4:0] obs_s = {state_s, tcb_irq_s, reset_s, pending_s};
    wire [4:0] obs_l = {state_l, tcb_irq_l, reset_l, pending_l};

    // Expected {state, tcb_irq, reset, pending}
    localparam logic [4:0] E_IDLE  = 5'b00_0_0_0;
    localparam logic [4:0] E_IDLEP = 5'b00_0_0_1;
    localparam logic [4:0] E_REQ   = 5'b01_1_0_1;
    localparam logic [4:0] E_RUN   = 5'b10_0_0_0;
    localparam logic [4:0] E_RUNP  = 5'b10_0_0_1;
    localparam logic [4:0] E_VIOL  = 5'b11_0_1_0;

    typedef struct {
        logic [15:0] pc;
        logic        irq;
        logic        dma;
        logic        rst_n;
        logic [4:0]  exp;
    } step_t;

    step_t      steps[$];
    logic [4:0] exp_q[$];
    int         n_total = 0;
    int         n_pass  = 0;

    task automatic add(input logic [15:0] p, input logic i, input logic d,
                       input logic r, input logic [4:0] e);
        step_t s;
        s.pc = p; s.irq = i; s.dma = d; s.rst_n = r; s.exp = e;
        steps.push_back(s);
    endtask

    task automatic add_n(input int n, input logic [15:0] p, input logic [4:0] e);
        for (int k = 0; k < n; k++) add(p, 1'b0, 1'b0, 1'b1, e);
    endtask

    // Reset step, nine idle cycles outside the TCB, then the request (edge 10).
    task automatic add_to_req();
        add(16'h4400, 1'b0, 1'b0, 1'b0, E_IDLE);
        add_n(9, 16'h4400, E_IDLE);
        add(16'h4400, 1'b0, 1'b0, 1'b1, E_REQ);
    endtask

    // Applies the next step and queues its expectation. It then advances past
    // the clock edge and lands 1 time unit after it.
    task automatic drive_next();
        step_t s;
        s = steps.pop_front();
        rst_n  = s.rst_n;
        pc     = s.pc;
        irq    = s.irq;
        dma_en = s.dma;
        exp_q.push_back(s.exp);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int idx = 0;
        logic [4:0] want;
        add(16'h4400, 1'b0, 1'b0, 1'b0, E_IDLE);
        add(16'hA100, 1'b1, 1'b1, 1'b0, E_IDLE);
        while (steps.size() != 0) begin
            drive_next();
            want = exp_q.pop_front();
            n_total++;
            if (obs_s !== want) $display("FAIL reset_s step %0d: got %b required %b", idx, obs_s, want);
            else n_pass++;
            n_total++;
            if (obs_l !== want) $display("FAIL reset_l step %0d: got %b required %b", idx, obs_l, want);
            else n_pass++;
            idx++;
        end
    endtask

    task automatic test_legal_run();
        int idx = 0;
        logic [4:0] want;
        add_to_req();
        add(16'hA000, 1'b0, 1'b0, 1'b1, E_RUN);
        add(16'hDFFE, 1'b0, 1'b0, 1'b1, E_RUN);
        add(16'h4400, 1'b0, 1'b0, 1'b1, E_IDLE);
        add_n(6, 16'h4400, E_IDLE);
        add(16'h4400, 1'b0, 1'b0, 1'b1, E_REQ);
        // Unrequested but legal entry from IDLE
        add(16'h4400, 1'b0, 1'b0, 1'b0, E_IDLE);
        add(16'h4400, 1'b0, 1'b0, 1'b1, E_IDLE);
        add(16'hA000, 1'b0, 1'b0, 1'b1, E_RUN);
        add(16'hDFFE, 1'b0, 1'b0, 1'b1, E_RUN);
        add(16'h4400, 1'b0, 1'b0, 1'b1, E_IDLE);
        while (steps.size() != 0) begin
            drive_next();
            want = exp_q.pop_front();
            n_total++;
            if (obs_s !== want) $display("FAIL legal_run step %0d: got %b required %b", idx, obs_s, want);
            else n_pass++;
            idx++;
        end
    endtask

    task automatic test_req_timeout();
        int idx = 0;
        logic [4:0] want;
        add_to_req();
        add_n(5, 16'h4400, E_REQ);
        add(16'h4400, 1'b0, 1'b0, 1'b1, E_VIOL);
        add(16'h4400, 1'b0, 1'b0, 1'b1, E_VIOL);
        add(16'h0000, 1'b0, 1'b0, 1'b1, E_IDLE);
        add(16'h0000, 1'b0, 1'b0, 1'b1, E_IDLE);
        // Entry on the last allowed wait cycle is still legal
        add_to_req();
        add_n(5, 16'h4400, E_REQ);
        add(16'hA000, 1'b0, 1'b0, 1'b1, E_RUN);
        while (steps.size() != 0) begin
            drive_next();
            want = exp_q.pop_front();
            n_total++;
            if (obs_s !== want) $display("FAIL req_timeout step %0d: got %b required %b", idx, obs_s, want);
            else n_pass++;
            idx++;
        end
    endtask

    task automatic test_illegal_entry();
        int idx = 0;
        logic [4:0] want;
        add(16'h4400, 1'b0, 1'b0, 1'b0, E_IDLE);
        add(16'h4400, 1'b0, 1'b0, 1'b1, E_IDLE);
        add(16'hA010, 1'b0, 1'b0, 1'b1, E_VIOL);
        add(16'hA010, 1'b0, 1'b0, 1'b1, E_VIOL);
        add(16'h0000, 1'b0, 1'b0, 1'b1, E_IDLE);
        // Region boundaries: 9FFF and E000 lie outside, DFFF lies inside
        add(16'h0000, 1'b0, 1'b0, 1'b0, E_IDLE);
        add(16'h9FFF, 1'b0, 1'b0, 1'b1, E_IDLE);
        add(16'hE000, 1'b0, 1'b0, 1'b1, E_IDLE);
        add(16'hDFFF, 1'b0, 1'b0, 1'b1, E_VIOL);
        add(16'h0000, 1'b0, 1'b0, 1'b1, E_IDLE);
        // Illegal entry while a request is pending also clears pending
        add_to_req();
        add(16'hA010, 1'b0, 1'b0, 1'b1, E_VIOL);
        while (steps.size() != 0) begin
            drive_next();
            want = exp_q.pop_front();
            n_total++;
            if (obs_s !== want) $display("FAIL illegal_entry step %0d: got %b required %b", idx, obs_s, want);
            else n_pass++;
            idx++;
        end
    endtask

    task automatic test_illegal_exit();
        int idx = 0;
        logic [4:0] want;
        add_to_req();
        add(16'hA000, 1'b0, 1'b0, 1'b1, E_RUN);
        add(16'hA100, 1'b0, 1'b0, 1'b1, E_RUN);
        add(16'h4400, 1'b0, 1'b0, 1'b1, E_VIOL);
        add(16'h0000, 1'b0, 1'b0, 1'b1, E_IDLE);
        while (steps.size() != 0) begin
            drive_next();
            want = exp_q.pop_front();
            n_total++;
            if (obs_s !== want) $display("FAIL illegal_exit step %0d: got %b required %b", idx, obs_s, want);
            else n_pass++;
            idx++;
        end
    endtask

    task automatic test_atomicity();
        int idx = 0;
        logic [4:0] want;
        // irq and dma are harmless outside RUN
        add(16'h4400, 1'b0, 1'b0, 1'b0, E_IDLE);
        add(16'h4400, 1'b1, 1'b1, 1'b1, E_IDLE);
        add_to_req();
        add(16'hA000, 1'b0, 1'b0, 1'b1, E_RUN);
        add(16'hA100, 1'b1, 1'b0, 1'b1, E_VIOL);
        add(16'h0000, 1'b0, 1'b0, 1'b1, E_IDLE);
        add_to_req();
        add(16'hA000, 1'b0, 1'b0, 1'b1, E_RUN);
        add(16'hA100, 1'b0, 1'b1, 1'b1, E_VIOL);
        add(16'h0000, 1'b0, 1'b0, 1'b1, E_IDLE);
        while (steps.size() != 0) begin
            drive_next();
            want = exp_q.pop_front();
            n_total++;
            if (obs_s !== want) $display("FAIL atomicity step %0d: got %b required %b", idx, obs_s, want);
            else n_pass++;
            idx++;
        end
    endtask

    task automatic test_max_run();
        int idx = 0;
        logic [4:0] want;
        add_to_req();
        add(16'hA000, 1'b0, 1'b0, 1'b1, E_RUN);
        for (int k = 1; k <= 7; k++) add(16'hA000 + 16'(2 * k), 1'b0, 1'b0, 1'b1, E_RUN);
        add(16'hA0F0, 1'b0, 1'b0, 1'b1, E_VIOL);
        add(16'h0000, 1'b0, 1'b0, 1'b1, E_IDLE);
        // A legal exit on the last budget cycle is accepted
        add_to_req();
        add(16'hA000, 1'b0, 1'b0, 1'b1, E_RUN);
        for (int k = 1; k <= 6; k++) add(16'hA000 + 16'(2 * k), 1'b0, 1'b0, 1'b1, E_RUN);
        add(16'hDFFE, 1'b0, 1'b0, 1'b1, E_RUN);
        add(16'h4400, 1'b0, 1'b0, 1'b1, E_IDLE);
        while (steps.size() != 0) begin
            drive_next();
            want = exp_q.pop_front();
            n_total++;
            if (obs_s !== want) $display("FAIL max_run step %0d: got %b required %b", idx, obs_s, want);
            else n_pass++;
            idx++;
        end
    endtask

    task automatic test_overrun_and_reset();
        int idx = 0;
        logic [4:0] want;
        add_to_req();
        add(16'hA000, 1'b0, 1'b0, 1'b1, E_RUN);
        add_n(8, 16'hA100, E_RUN);
        add_n(10, 16'hA100, E_RUNP);
        add(16'hDFFE, 1'b0, 1'b0, 1'b1, E_RUNP);
        add(16'h4400, 1'b0, 1'b0, 1'b1, E_IDLEP);
        add(16'h4400, 1'b0, 1'b0, 1'b1, E_REQ);
        add(16'hA000, 1'b0, 1'b0, 1'b1, E_RUN);
        add(16'hA100, 1'b0, 1'b0, 1'b0, E_IDLE);
        add(16'h4400, 1'b0, 1'b0, 1'b1, E_IDLE);
        while (steps.size() != 0) begin
            drive_next();
            want = exp_q.pop_front();
            n_total++;
            if (obs_l !== want) $display("FAIL overrun_reset step %0d: got %b required %b", idx, obs_l, want);
            else n_pass++;
            idx++;
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        pc     = 16'h4400;
        irq    = 1'b0;
        dma_en = 1'b0;
        test_reset();
        test_legal_run();
        test_req_timeout();
        test_illegal_entry();
        test_illegal_exit();
        test_atomicity();
        test_max_run();
        test_overrun_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
